// File: rtl/ifetch_responder.sv
// Fetch-window responder: turns a halfword-granular fetch address into a 64-bit
// window of four halfwords, assembled from two or three 32-bit bus word reads.
module ifetch_responder #(
    parameter int PC_W    = 25,
    parameter int WORD_AW = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [PC_W-1:0]    req_addr_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [63:0]        rsp_data_o,
    output logic [PC_W-1:0]    rsp_addr_o,
    output logic               bus_req_o,
    output logic [WORD_AW-1:0] bus_addr_o,
    input  logic               bus_ack_i,
    input  logic [31:0]        bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [1:0]         beat_q, beat_d;
    logic [95:0]        buf_q, buf_d;
    logic               busReq_q, busReq_d;
    logic [WORD_AW-1:0] busAddr_q, busAddr_d;
    logic               rspValid_q, rspValid_d;
    logic [63:0]        rspData_q, rspData_d;
    logic [PC_W-1:0]    rspAddr_q, rspAddr_d;

    logic [1:0]  lastBeat;
    logic [95:0] bufIns;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            buf_q      <= '0;
            busReq_q   <= 1'b0;
            busAddr_q  <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspAddr_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            buf_q      <= buf_d;
            busReq_q   <= busReq_d;
            busAddr_q  <= busAddr_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            rspAddr_q  <= rspAddr_d;
        end
    end

    // The window is assembled from the buffer with the current beat already
    // inserted, so the response is ready the cycle after the final ack.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        busReq_d   = busReq_q;
        busAddr_d  = busAddr_q;
        rspValid_d = rspValid_q;
        rspData_d  = rspData_q;
        rspAddr_d  = rspAddr_q;

        lastBeat = addr_q[0] ? 2'd2 : 2'd1;
        bufIns   = buf_q;
        case (beat_q)
            2'd0:    bufIns[31:0]  = bus_rdata_i;
            2'd1:    bufIns[63:32] = bus_rdata_i;
            default: bufIns[95:64] = bus_rdata_i;
        endcase

        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    addr_d    = req_addr_i;
                    busAddr_d = req_addr_i[PC_W-1:1];
                    busReq_d  = 1'b1;
                    beat_d    = 2'd0;
                    buf_d     = '0;
                    state_d   = READ;
                end
            end
            READ: begin
                if (flush_i) begin
                    if (bus_ack_i) begin
                        busReq_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d  = DRAIN;
                    end
                end else if (bus_ack_i) begin
                    buf_d  = bufIns;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == lastBeat) begin
                        busReq_d   = 1'b0;
                        rspValid_d = 1'b1;
                        rspData_d  = addr_q[0] ? bufIns[79:16] : bufIns[63:0];
                        rspAddr_d  = addr_q;
                        state_d    = RESP;
                    end else begin
                        busAddr_d  = busAddr_q + WORD_AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus_ack_i) begin
                    busReq_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RESP: begin
                if (flush_i || rsp_ready_i) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;
    assign rsp_addr_o  = rspAddr_q;
    assign bus_req_o   = busReq_q;
    assign bus_addr_o  = busAddr_q;

endmodule

// File: tb/tb_ifetch_responder.sv
// Scoreboard bench for ifetch_responder: a memory-backed bus responder, a
// queue of expected windows, and a monitor that checks each response handshake.
module tb_ifetch_responder;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [24:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic [24:0] rsp_addr_o;
    logic        bus_req_o;
    logic [23:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    ifetch_responder #(.PC_W(25), .WORD_AW(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_addr_o  (rsp_addr_o),
        .bus_req_o   (bus_req_o),
        .bus_addr_o  (bus_addr_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    typedef struct {
        logic [24:0] addr;
        logic [63:0] data;
        int          accCycle;
        int          lat;
    } exp_t;

    exp_t        expQ[$];
    logic [23:0] busLog[$];
    int          errors = 0;
    int          checks = 0;
    int          cycleCnt = 0;
    int          rspCount = 0;
    int          busWait = 0;
    bit          busRandom = 0;
    bit          rdyRandom = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] memWord(input logic [23:0] w);
        return 32'h1111_0000 + {8'h00, w};
    endfunction

    // Reference: the window is simply halfwords addr..addr+3 taken modulo the PC space.
    function automatic logic [63:0] expWindow(input logic [24:0] a);
        logic [63:0] win;
        logic [24:0] p;
        logic [31:0] word;
        win = '0;
        for (int k = 0; k < 4; k++) begin
            p    = a + 25'(k);
            word = memWord(p[24:1]);
            win[16*k +: 16] = p[0] ? word[31:16] : word[15:0];
        end
        return win;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic [24:0] a, input int lat);
        bit   ok;
        exp_t e;
        ok = 0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                e.addr     = a;
                e.data     = expWindow(a);
                e.accCycle = cycleCnt;
                e.lat      = lat;
                expQ.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        if (!ok) checkOutput("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic waitIdle();
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus_req_o && !rsp_valid_o) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("idle_timeout", 128'(0), 128'(1));
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int nextWait();
        return busRandom ? int'($urandom_range(0, 2)) : busWait;
    endfunction

    // Bus responder: acks after a configurable number of wait cycles and checks
    // that the request address does not move while a beat is outstanding.
    initial begin
        int          waitCnt;
        int          waitTarget;
        bit          pendPrev;
        logic [23:0] holdAddr;
        waitCnt = 0;
        waitTarget = 0;
        pendPrev = 0;
        holdAddr = '0;
        bus_ack_i = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst || !bus_req_o) begin
                bus_ack_i  = 1'b0;
                waitCnt    = 0;
                waitTarget = nextWait();
                pendPrev   = 0;
            end else begin
                if (pendPrev) checkOutput("bus_addr_hold", 128'(bus_addr_o), 128'(holdAddr));
                holdAddr = bus_addr_o;
                if (waitCnt >= waitTarget) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = memWord(bus_addr_o);
                    busLog.push_back(bus_addr_o);
                    waitCnt     = 0;
                    waitTarget  = nextWait();
                    pendPrev    = 0;
                end else begin
                    bus_ack_i   = 1'b0;
                    waitCnt++;
                    pendPrev    = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdyRandom) rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each response handshake; a flush voids
    // whatever request is in flight.
    logic        prevValid = 1'b0;
    logic        prevFire = 1'b0;
    logic [63:0] prevData = '0;
    logic [24:0] prevAddr = '0;
    exp_t        popE;

    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
            prevFire  = 1'b0;
        end else begin
            if (rsp_valid_o && !prevValid) begin
                rspCount++;
                if (expQ.size() == 0)
                    checkOutput("unexpected_rsp", 128'(1), 128'(0));
                else if (expQ[0].lat >= 0)
                    checkOutput("rsp_latency", 128'(cycleCnt - expQ[0].accCycle), 128'(expQ[0].lat));
            end
            if (rsp_valid_o && prevValid && !prevFire) begin
                checkOutput("rsp_hold_data", 128'(rsp_data_o), 128'(prevData));
                checkOutput("rsp_hold_addr", 128'(rsp_addr_o), 128'(prevAddr));
            end
            if (flush_i) begin
                if (expQ.size() > 0) popE = expQ.pop_front();
            end else if (rsp_valid_o && rsp_ready_i && expQ.size() > 0) begin
                popE = expQ.pop_front();
                checkOutput("rsp_data", 128'(rsp_data_o), 128'(popE.data));
                checkOutput("rsp_addr", 128'(rsp_addr_o), 128'(popE.addr));
            end
            prevValid = rsp_valid_o;
            prevFire  = flush_i || rsp_ready_i;
            prevData  = rsp_data_o;
            prevAddr  = rsp_addr_o;
        end
    end

    task automatic checkBusLog(input string name, input logic [23:0] w0, input logic [23:0] w1,
                               input logic [23:0] w2, input int n);
        logic [23:0] want[3];
        want[0] = w0;
        want[1] = w1;
        want[2] = w2;
        checkOutput({name, "_count"}, 128'(busLog.size()), 128'(n));
        for (int i = 0; i < n && i < busLog.size(); i++)
            checkOutput({name, "_word"}, 128'(busLog[i]), 128'(want[i]));
    endtask

    initial begin
        int          rspBefore;
        logic [24:0] a;
        rst = 1'b1;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        rsp_ready_i = 1'b1;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", 128'(rsp_valid_o), 128'(0));
        checkOutput("reset_rsp_data", 128'(rsp_data_o), 128'(0));
        checkOutput("reset_rsp_addr", 128'(rsp_addr_o), 128'(0));
        checkOutput("reset_bus_req", 128'(bus_req_o), 128'(0));
        checkOutput("reset_bus_addr", 128'(bus_addr_o), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 128'(req_ready_o), 128'(1));

        // Flush in IDLE blocks acceptance
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i = 25'h10;
        @(negedge clk);
        checkOutput("flush_idle_ready", 128'(req_ready_o), 128'(0));
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_idle_no_bus", 128'(bus_req_o), 128'(0));
        @(posedge clk);
        #1;

        // Even fetch, zero wait
        busLog.delete();
        applyStimulus(25'h10, 3);
        waitIdle();
        checkBusLog("even_bus", 24'h8, 24'h9, 24'h0, 2);
        checkOutput("even_data_const", 128'(rsp_data_o), 128'(64'h1111_0009_1111_0008));

        // Odd fetch, zero wait
        busLog.delete();
        applyStimulus(25'h11, 4);
        waitIdle();
        checkBusLog("odd_bus", 24'h8, 24'h9, 24'hA, 3);

        // Wait states plus a stalled consumer
        busLog.delete();
        busWait = 2;
        rsp_ready_i = 1'b0;
        applyStimulus(25'h10, 7);
        for (int i = 0; i < 100 && !rsp_valid_o; i++) stepCycles(1);
        stepCycles(5);
        rsp_ready_i = 1'b1;
        waitIdle();
        checkBusLog("wait_bus", 24'h8, 24'h9, 24'h0, 2);

        // Flush while the first beat of an odd fetch is outstanding
        busLog.delete();
        busWait = 3;
        rspBefore = rspCount;
        applyStimulus(25'h11, -1);
        flush_i = 1'b1;
        stepCycles(1);
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("drain_req_held", 128'(bus_req_o), 128'(1));
        checkOutput("drain_addr_held", 128'(bus_addr_o), 128'(24'h8));
        checkOutput("drain_not_ready", 128'(req_ready_o), 128'(0));
        @(posedge clk);
        #1;
        waitIdle();
        stepCycles(5);
        checkOutput("flush_beats", 128'(busLog.size()), 128'(1));
        checkOutput("flush_no_rsp", 128'(rspCount), 128'(rspBefore));
        busWait = 0;
        applyStimulus(25'h11, 4);
        waitIdle();

        // Address wrap
        busLog.delete();
        applyStimulus(25'h1FF_FFFF, 4);
        waitIdle();
        checkBusLog("wrap_bus", 24'hFF_FFFF, 24'h0, 24'h1, 3);

        // Randomized traffic with random wait states, back-pressure and flushes
        busRandom = 1;
        rdyRandom = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) a = 25'h1FF_FFFF - 25'($urandom_range(0, 3));
            else a = 25'($urandom);
            applyStimulus(a, -1);
            if ($urandom_range(0, 4) == 0) begin
                stepCycles($urandom_range(0, 6));
                flush_i = 1'b1;
                stepCycles(1);
                flush_i = 1'b0;
            end
            waitIdle();
        end
        rdyRandom = 0;
        rsp_ready_i = 1'b1;
        stepCycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
